quad_encoder_gen: RTL

- Multi-channel quadrature encoder synthesiser for paddle/spinner arcade cores.
- Converts digital left/right, signed analog stick, or absolute paddle position into A/B quadrature pulses per channel.
- Auto-selects a physical encoder on user-port pins whenever one is active.
- Sits between the hps_io/joystick layer and the game core's Enc_A/Enc_B inputs; replaces the single-channel joystick-to-quadrature path plus its ad-hoc user-port select logic.

---
 rtl/quad_encoder_gen_if.sv | 29 ++
 rtl/quad_encoder_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_gen_if.sv
// Bundle of per-channel control inputs and quadrature outputs for
// quad_encoder_gen. The joystick/hps_io side is the master, the encoder
// synthesiser is the slave.
interface quad_encoder_gen_if #(
    parameter int CHANNELS = 2,
    parameter int POS_W    = 8
);
    logic [2*CHANNELS-1:0]     mode;
    logic [CHANNELS-1:0]       left;
    logic [CHANNELS-1:0]       right;
    logic [8*CHANNELS-1:0]     analog;
    logic [CHANNELS-1:0]       ext_a;
    logic [CHANNELS-1:0]       ext_b;
    logic                      ext_en;
    logic [CHANNELS-1:0]       enc_a;
    logic [CHANNELS-1:0]       enc_b;
    logic [CHANNELS-1:0]       src_ext;
    logic [POS_W*CHANNELS-1:0] position;

    modport master (
        output mode, left, right, analog, ext_a, ext_b, ext_en,
        input  enc_a, enc_b, src_ext, position
    );

    modport slave (
        input  mode, left, right, analog, ext_a, ext_b, ext_en,
        output enc_a, enc_b, src_ext, position
    );
endinterface

// File: rtl/quad_encoder_gen.sv
// Multi-channel quadrature encoder synthesiser for paddle/spinner cores.
// Each channel turns digital left/right, a signed analog stick or an
// absolute paddle position into A/B quadrature steps, and hands the outputs
// over to a physical encoder on the user port whenever that one moves.
// Optional build macro QUAD_EXT_FILTER_EN adds a 4-cycle stability filter
// on the synchronised external encoder inputs.
module quad_encoder_gen #(
    parameter int CHANNELS    = 2,
    parameter int DIV_W       = 16,
    parameter int DIV_SLOW    = 5500,
    parameter int DIV_FAST    = 1375,
    parameter int ACCEL_STEPS = 32,
    parameter int POS_W       = 8
) (
    input  logic              clk_sys,
    input  logic              reset,
    quad_encoder_gen_if.slave bus
);
    localparam int ACC_W = $clog2(ACCEL_STEPS + 2);
    localparam logic [DIV_W-1:0] SLOW_P  = DIV_W'(DIV_SLOW);
    localparam logic [DIV_W-1:0] FAST_P  = DIV_W'(DIV_FAST);
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(ACCEL_STEPS);

    logic [CHANNELS-1:0]       enc_a_w;
    logic [CHANNELS-1:0]       enc_b_w;
    logic [CHANNELS-1:0]       src_w;
    logic [POS_W*CHANNELS-1:0] pos_w;

    genvar gi;
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [1:0]       md;
        logic [7:0]       an;
        logic [1:0]       ext_raw;
        logic [1:0]       sync1_q, sync2_q, ext_val, ext_prev_q;
        logic [1:0]       phase_q, phase_d;
        logic [POS_W-1:0] pos_q, pos_d, target;
        logic [DIV_W-1:0] div_q, div_d, div_cur, period, an_period;
        logic [ACC_W-1:0] accel_q, accel_d, acc_cur;
        logic [1:0]       mode_q;
        logic             req_q, dir_q, src_q, src_d;
        logic [1:0]       enc_q, enc_d;
        logic             req, dir_up, restart, step, ext_chg;
        logic [7:0]       s_val;
        logic [6:0]       mag;

        assign md      = bus.mode[2*gi +: 2];
        assign an      = bus.analog[8*gi +: 8];
        assign ext_raw = {bus.ext_a[gi], bus.ext_b[gi]};

        // Two-flop synchroniser for the asynchronous user-port encoder pins
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                sync1_q <= 2'b00;
                sync2_q <= 2'b00;
            end else begin
                sync1_q <= ext_raw;
                sync2_q <= sync1_q;
            end
        end

`ifdef QUAD_EXT_FILTER_EN
        logic [1:0]      filt_q;
        logic [1:0][1:0] stab_q;

        // Accept a new pin level only after it has differed from the
        // filtered value for four consecutive cycles
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                filt_q <= 2'b00;
                stab_q <= '0;
            end else begin
                for (int b = 0; b < 2; b++) begin
                    if (sync2_q[b] == filt_q[b]) begin
                        stab_q[b] <= 2'd0;
                    end else if (stab_q[b] == 2'd3) begin
                        filt_q[b] <= sync2_q[b];
                        stab_q[b] <= 2'd0;
                    end else begin
                        stab_q[b] <= stab_q[b] + 2'd1;
                    end
                end
            end
        end

        assign ext_val = filt_q;
`else
        assign ext_val = sync2_q;
`endif

        // Step request, period selection and next-state for one channel
        always_comb begin
            s_val = an ^ 8'h80;
            if (!s_val[7])                mag = s_val[6:0];
            else if (s_val[6:0] == 7'd0)  mag = 7'h7F;   // -128 clamps to 127
            else                          mag = ~s_val[6:0] + 7'd1;
            an_period = SLOW_P >> mag[6:5];
            if (an_period < FAST_P) an_period = FAST_P;
            target = POS_W'(an);

            req    = 1'b0;
            dir_up = 1'b0;
            case (md)
                2'b00: begin
                    req    = bus.left[gi] ^ bus.right[gi];
                    dir_up = bus.right[gi];
                end
                2'b01: begin
                    req    = (mag >= 7'd16);
                    dir_up = ~s_val[7];
                end
                2'b10: begin
                    req    = (pos_q != target);
                    dir_up = (target > pos_q);
                end
                default: ;
            endcase

            // A mode change or a digital reversal starts timing afresh,
            // exactly as if the request had just appeared
            restart = (md != mode_q) ||
                      ((md == 2'b00) && req && req_q && (dir_up != dir_q));
            div_cur = restart ? '0 : div_q;
            acc_cur = restart ? '0 : accel_q;

            case (md)
                2'b00:   period = (acc_cur >= ACC_MAX) ? FAST_P : SLOW_P;
                2'b01:   period = an_period;
                default: period = FAST_P;
            endcase

            step  = req && (div_cur == period - DIV_W'(1));
            div_d = (!req || step) ? '0 : div_cur + DIV_W'(1);

            accel_d = '0;
            if ((md == 2'b00) && req)
                accel_d = (step && (acc_cur < ACC_MAX)) ? acc_cur + ACC_W'(1) : acc_cur;

            phase_d = phase_q;
            pos_d   = pos_q;
            if (step) begin
                if (dir_up) begin
                    phase_d = {phase_q[0], ~phase_q[1]};
                    pos_d   = pos_q + POS_W'(1);
                end else begin
                    phase_d = {~phase_q[0], phase_q[1]};
                    pos_d   = pos_q - POS_W'(1);
                end
            end

            // Internal stepping always reclaims the channel
            ext_chg = bus.ext_en && (ext_val != ext_prev_q);
            if (!bus.ext_en || step) src_d = 1'b0;
            else if (ext_chg)        src_d = 1'b1;
            else                     src_d = src_q;

            enc_d = src_d ? ext_val : phase_d;
        end

        // Channel state and registered quadrature outputs
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                phase_q    <= 2'b00;
                pos_q      <= '0;
                div_q      <= '0;
                accel_q    <= '0;
                mode_q     <= 2'b00;
                req_q      <= 1'b0;
                dir_q      <= 1'b0;
                src_q      <= 1'b0;
                enc_q      <= 2'b00;
                ext_prev_q <= 2'b00;
            end else begin
                phase_q    <= phase_d;
                pos_q      <= pos_d;
                div_q      <= div_d;
                accel_q    <= accel_d;
                mode_q     <= md;
                req_q      <= req;
                if (req) dir_q <= dir_up;
                src_q      <= src_d;
                enc_q      <= enc_d;
                ext_prev_q <= ext_val;
            end
        end

        assign enc_a_w[gi]              = enc_q[1];
        assign enc_b_w[gi]              = enc_q[0];
        assign src_w[gi]                = src_q;
        assign pos_w[POS_W*gi +: POS_W] = pos_q;
    end

    assign bus.enc_a    = enc_a_w;
    assign bus.enc_b    = enc_b_w;
    assign bus.src_ext  = src_w;
    assign bus.position = pos_w;
endmodule
